axi4_stream_pkt_fifo: RTL and testbench

- Parametrised next-generation single-clock AXI4-Stream FIFO with a selectable mode: backpressured cut-through or store-and-forward with whole-packet drop.
- Store-and-forward adds a committed write pointer, so rollback is a single pointer restore instead of arithmetic on packet word counts.
- Adds optional error-packet discard (tuser[0] on tlast), almost-full/almost-empty flags and a saturating drop counter.
- Sits between stream producers (MAC, video capture) and consumers that need only complete packets.

---
 rtl/axi4_stream_pkt_fifo_if.sv | 18 +
 rtl/axi4_stream_pkt_fifo.sv | 137 +++++++++++++
 tb/tb_axi4_stream_pkt_fifo.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_pkt_fifo_if.sv
// axi4_stream_if: AXI4-Stream bundle with master and slave views.
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TID_WIDTH   = 1
);
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic                     tlast;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TID_WIDTH-1:0]     tid;
    modport master (output tvalid, tdata, tkeep, tlast, tuser, tdest, tid, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, tdest, tid, output tready);
endinterface

// File: rtl/axi4_stream_pkt_fifo.sv
// axi4_stream_pkt_fifo: AXI4-Stream FIFO, cut-through or store-and-forward with packet drop.
module axi4_stream_pkt_fifo #(
    parameter int TDATA_WIDTH  = 32,
    parameter int TUSER_WIDTH  = 1,
    parameter int TDEST_WIDTH  = 1,
    parameter int TID_WIDTH    = 1,
    parameter int WORDS_AMOUNT = 16,
    parameter int STORE_FWD    = 1,
    parameter int DROP_ON_ERR  = 0,
    parameter int AFULL_LVL    = WORDS_AMOUNT - 2,
    parameter int AEMPTY_LVL   = 2,
    parameter int ADDR_WIDTH   = $clog2(WORDS_AMOUNT)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    axi4_stream_if.slave          pkt_i,
    axi4_stream_if.master         pkt_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   used_words_o,
    output logic [ADDR_WIDTH:0]   pkts_amount_o,
    output logic                  drop_o,
    output logic [15:0]           drop_cnt_o
);
    localparam int W = TDATA_WIDTH + TDATA_WIDTH / 8 + 1 + TUSER_WIDTH + TDEST_WIDTH + TID_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH  = (ADDR_WIDTH + 1)'(WORDS_AMOUNT);
    localparam logic [ADDR_WIDTH:0] AFULL  = (ADDR_WIDTH + 1)'(AFULL_LVL);
    localparam logic [ADDR_WIDTH:0] AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_LVL);

    typedef enum logic {ACCEPT, DROP} state_t;
    state_t st_q, st_d;

    logic [W-1:0]        mem_q [WORDS_AMOUNT];
    logic [W-1:0]        ram_q, out_q, out_d, wdat;
    logic [ADDR_WIDTH:0] wr_q, wr_d, cmt_q, cmt_d, rd_q, rd_d, fe_q, fe_d, pkts_q, pkts_d;
    logic [ADDR_WIDTH:0] occ, lim;
    logic [15:0]         dcnt_q, dcnt_d;
    logic                ram_vld_q, ram_vld_d, out_vld_q, out_vld_d;
    logic                full, wr_en, commit, drop, err, pop, mv, ren, rd_last;

    // rd_q advances on consumption, so words still in the output stage keep their RAM slot
    assign occ     = wr_q - rd_q;
    assign full    = occ == DEPTH;
    assign lim     = STORE_FWD != 0 ? cmt_q : wr_q;
    assign err     = DROP_ON_ERR != 0 && pkt_i.tuser[0];
    assign wdat    = {pkt_i.tdata, pkt_i.tkeep, pkt_i.tlast, pkt_i.tuser, pkt_i.tdest, pkt_i.tid};
    assign pop     = out_vld_q && pkt_o.tready;
    assign mv      = ram_vld_q && (!out_vld_q || pop);
    assign ren     = fe_q != lim && (!ram_vld_q || mv);
    assign rd_last = pop && pkt_o.tlast;

    always_comb begin
        st_d   = st_q;
        wr_d   = wr_q;
        cmt_d  = cmt_q;
        wr_en  = 1'b0;
        commit = 1'b0;
        drop   = 1'b0;
        if (STORE_FWD == 0) begin
            wr_en  = pkt_i.tvalid && !full;
            wr_d   = wr_en ? wr_q + ONE : wr_q;
            commit = wr_en && pkt_i.tlast;
            cmt_d  = wr_d;
        end else if (st_q == ACCEPT) begin
            if (pkt_i.tvalid && full) begin
                wr_d = cmt_q;
                drop = pkt_i.tlast;
                st_d = pkt_i.tlast ? ACCEPT : DROP;
            end else if (pkt_i.tvalid) begin
                wr_en  = 1'b1;
                commit = pkt_i.tlast && !err;
                drop   = pkt_i.tlast && err;
                wr_d   = drop ? cmt_q : wr_q + ONE;
                cmt_d  = commit ? wr_q + ONE : cmt_q;
            end
        end else if (pkt_i.tvalid && pkt_i.tlast) begin
            drop = 1'b1;
            st_d = ACCEPT;
        end
    end

    always_comb begin
        fe_d      = ren ? fe_q + ONE : fe_q;
        rd_d      = pop ? rd_q + ONE : rd_q;
        ram_vld_d = ren || (ram_vld_q && !mv);
        out_vld_d = mv || (out_vld_q && !pop);
        out_d     = mv ? ram_q : out_q;
        pkts_d    = (commit && !rd_last) ? pkts_q + ONE : (!commit && rd_last) ? pkts_q - ONE : pkts_q;
        dcnt_d    = (drop && dcnt_q != 16'hFFFF) ? dcnt_q + 16'd1 : dcnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_q[ADDR_WIDTH-1:0]] <= wdat;
        if (ren) ram_q <= mem_q[fe_q[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st_q      <= ACCEPT;
            wr_q      <= '0;
            cmt_q     <= '0;
            rd_q      <= '0;
            fe_q      <= '0;
            pkts_q    <= '0;
            dcnt_q    <= '0;
            ram_vld_q <= 1'b0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            st_q      <= st_d;
            wr_q      <= wr_d;
            cmt_q     <= cmt_d;
            rd_q      <= rd_d;
            fe_q      <= fe_d;
            pkts_q    <= pkts_d;
            dcnt_q    <= dcnt_d;
            ram_vld_q <= ram_vld_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
        end
    end

    assign pkt_i.tready   = STORE_FWD != 0 ? 1'b1 : !full;
    assign pkt_o.tvalid   = out_vld_q;
    assign {pkt_o.tdata, pkt_o.tkeep, pkt_o.tlast, pkt_o.tuser, pkt_o.tdest, pkt_o.tid} = out_q;
    assign full_o         = full;
    assign empty_o        = !out_vld_q;
    assign almost_full_o  = occ >= AFULL;
    assign almost_empty_o = occ <= AEMPTY;
    assign used_words_o   = occ;
    assign pkts_amount_o  = pkts_q;
    assign drop_o         = drop;
    assign drop_cnt_o     = dcnt_q;
endmodule

// File: tb/tb_axi4_stream_pkt_fifo.sv
// tb_axi4_stream_pkt_fifo: scoreboard bench for store-and-forward and cut-through instances.
module tb_axi4_stream_pkt_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_stream_if #(.TDATA_WIDTH(32)) sf_in ();
    axi4_stream_if #(.TDATA_WIDTH(32)) sf_out ();
    axi4_stream_if #(.TDATA_WIDTH(32)) ct_in ();
    axi4_stream_if #(.TDATA_WIDTH(32)) ct_out ();

    logic        sf_full, sf_empty, sf_af, sf_ae, sf_drop;
    logic [4:0]  sf_used, sf_pkts;
    logic [15:0] sf_dcnt;
    logic        ct_full, ct_empty, ct_af, ct_ae, ct_drop;
    logic [4:0]  ct_used, ct_pkts;
    logic [15:0] ct_dcnt;

    axi4_stream_pkt_fifo #(.WORDS_AMOUNT(16), .STORE_FWD(1), .DROP_ON_ERR(1)) u_sf (
        .clk_i(clk), .rst_n_i(rst_n), .pkt_i(sf_in), .pkt_o(sf_out),
        .full_o(sf_full), .empty_o(sf_empty), .almost_full_o(sf_af), .almost_empty_o(sf_ae),
        .used_words_o(sf_used), .pkts_amount_o(sf_pkts), .drop_o(sf_drop), .drop_cnt_o(sf_dcnt));

    axi4_stream_pkt_fifo #(.WORDS_AMOUNT(16), .STORE_FWD(0)) u_ct (
        .clk_i(clk), .rst_n_i(rst_n), .pkt_i(ct_in), .pkt_o(ct_out),
        .full_o(ct_full), .empty_o(ct_empty), .almost_full_o(ct_af), .almost_empty_o(ct_ae),
        .used_words_o(ct_used), .pkts_amount_o(ct_pkts), .drop_o(ct_drop), .drop_cnt_o(ct_dcnt));

    int n_tests = 0;
    int n_fail = 0;
    logic [32:0] sf_q[$];
    logic [32:0] ct_q[$];
    int  sf_drops = 0;
    int  ct_occ = 0;
    int  ct_stalls = 0;
    bit  ct_drop_seen = 0;
    bit  sf_vld_seen = 0;
    logic sf_drop_s;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sf_out.tvalid) sf_vld_seen = 1;
        if (sf_drop) sf_drops++;
        if (sf_out.tvalid && sf_out.tready) begin
            if (sf_q.size() == 0) chk("sf_unexpected_beat", {sf_out.tlast, sf_out.tdata}, -1);
            else chk("sf_beat", {sf_out.tlast, sf_out.tdata}, sf_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (ct_drop) ct_drop_seen = 1;
        chk("ct_used", ct_used, ct_occ);
        chk("ct_tready", ct_in.tready, ct_occ != 16);
        if (!ct_in.tready) ct_stalls++;
        if (ct_out.tvalid && ct_out.tready) begin
            if (ct_q.size() == 0) chk("ct_unexpected_beat", {ct_out.tlast, ct_out.tdata}, -1);
            else chk("ct_beat", {ct_out.tlast, ct_out.tdata}, ct_q.pop_front());
        end
        ct_occ += int'(ct_in.tvalid && ct_in.tready) - int'(ct_out.tvalid && ct_out.tready);
    end

    task automatic sf_beat(input logic [31:0] d, input logic last, input logic usr);
        sf_in.tvalid = 1'b1;
        sf_in.tdata  = d;
        sf_in.tlast  = last;
        sf_in.tuser  = usr;
        @(negedge clk);
        sf_drop_s = sf_drop;
        @(posedge clk);
        #1;
        sf_in.tvalid = 1'b0;
    endtask

    task automatic sf_pkt(input int n, input logic [31:0] base, input bit err, input bit expect_out);
        for (int i = 0; i < n; i++) begin
            if (expect_out) sf_q.push_back({i == n - 1, base + 32'(i)});
            sf_beat(base + 32'(i), i == n - 1, err && i == n - 1);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int base, sent, cyc;
        sf_in.tvalid = 0; sf_in.tdata = 0; sf_in.tkeep = '1; sf_in.tlast = 0;
        sf_in.tuser = 0; sf_in.tdest = 0; sf_in.tid = 0;
        ct_in.tvalid = 0; ct_in.tdata = 0; ct_in.tkeep = '1; ct_in.tlast = 0;
        ct_in.tuser = 0; ct_in.tdest = 0; ct_in.tid = 0;
        sf_out.tready = 1; ct_out.tready = 1;
        @(posedge clk);
        #1;
        chk("rst_tvalid", sf_out.tvalid, 0);
        chk("rst_empty", sf_empty, 1);
        chk("rst_aempty", sf_ae, 1);
        chk("rst_used", sf_used, 0);
        chk("rst_pkts", sf_pkts, 0);
        chk("rst_dcnt", sf_dcnt, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        // 5-word packet: latency and bubble-free drain
        sf_pkt(5, 32'h100, 0, 1);
        chk("t1_tvalid_n0", sf_out.tvalid, 0);
        chk("t1_pkts", sf_pkts, 1);
        chk("t1_used", sf_used, 5);
        cycles(1);
        chk("t1_tvalid_n1", sf_out.tvalid, 0);
        cycles(1);
        chk("t1_tvalid_n2", sf_out.tvalid, 1);
        cycles(5);
        chk("t1_drained_tvalid", sf_out.tvalid, 0);
        chk("t1_drained_pkts", sf_pkts, 0);
        chk("t1_drained_used", sf_used, 0);
        // overflow of second packet while output stalled
        sf_out.tready = 0;
        base = sf_drops;
        sf_pkt(10, 32'h200, 0, 1);
        chk("t2_af_10", sf_af, 0);
        for (int i = 0; i < 6; i++) sf_beat(32'h300 + 32'(i), 0, 0);
        chk("t2_full", sf_full, 1);
        chk("t2_af_16", sf_af, 1);
        sf_beat(32'h306, 0, 0);
        chk("t2_drop_early", sf_drops - base, 0);
        sf_beat(32'h307, 1, 0);
        chk("t2_drop_on_tlast", sf_drop_s, 1);
        chk("t2_drops", sf_drops - base, 1);
        chk("t2_dcnt", sf_dcnt, 1);
        chk("t2_used", sf_used, 10);
        chk("t2_pkts", sf_pkts, 1);
        sf_out.tready = 1;
        cycles(15);
        chk("t2_used_end", sf_used, 0);
        chk("t2_pkts_end", sf_pkts, 0);
        // oversize packet dropped, then a normal one
        base = sf_drops;
        sf_vld_seen = 0;
        sf_pkt(20, 32'h400, 0, 0);
        cycles(3);
        chk("t3_no_tvalid", sf_vld_seen, 0);
        chk("t3_drops", sf_drops - base, 1);
        chk("t3_dcnt", sf_dcnt, 2);
        chk("t3_used", sf_used, 0);
        sf_pkt(3, 32'h500, 0, 1);
        cycles(8);
        chk("t3_used_end", sf_used, 0);
        chk("t3_pkts_end", sf_pkts, 0);
        // reset mid-packet: 3 committed + 4 uncommitted words
        sf_out.tready = 0;
        sf_pkt(3, 32'h600, 0, 1);
        for (int i = 0; i < 4; i++) sf_beat(32'h700 + 32'(i), 0, 0);
        chk("t6_used_pre", sf_used, 7);
        chk("t6_tvalid_pre", sf_out.tvalid, 1);
        rst_n = 0;
        #1;
        sf_q.delete();
        chk("t6_tvalid", sf_out.tvalid, 0);
        chk("t6_used", sf_used, 0);
        chk("t6_pkts", sf_pkts, 0);
        chk("t6_empty", sf_empty, 1);
        chk("t6_aempty", sf_ae, 1);
        chk("t6_dcnt", sf_dcnt, 0);
        cycles(2);
        @(negedge clk);
        rst_n = 1;
        sf_out.tready = 1;
        @(posedge clk);
        #1;
        // 14-word prefill after reset, then an error packet straddling address 0
        sf_pkt(14, 32'h800, 0, 1);
        cycles(20);
        chk("t4_prefill_used", sf_used, 0);
        base = sf_drops;
        sf_pkt(4, 32'h900, 1, 0);
        chk("t4_drop_on_tlast", sf_drop_s, 1);
        chk("t4_dcnt", sf_dcnt, 1);
        chk("t4_used", sf_used, 0);
        sf_pkt(4, 32'hA00, 0, 1);
        cycles(8);
        chk("t4_drops", sf_drops - base, 1);
        chk("t4_used_end", sf_used, 0);
        chk("t4_pkts_end", sf_pkts, 0);
        // cut-through, random consumer
        sent = 0;
        cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            logic acc;
            ct_in.tvalid = 1;
            ct_in.tdata  = 32'(sent);
            ct_in.tlast  = sent % 8 == 7;
            ct_out.tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = ct_in.tready;
            if (acc) ct_q.push_back({ct_in.tlast, ct_in.tdata});
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
        end
        chk("t5_all_sent", sent, 1000);
        ct_in.tvalid = 0;
        ct_out.tready = 1;
        cyc = 0;
        while (ct_q.size() != 0 && cyc < 200) begin
            cycles(1);
            cyc++;
        end
        cycles(2);
        chk("t5_queue_drained", ct_q.size(), 0);
        chk("t5_used_end", ct_used, 0);
        chk("t5_pkts_end", ct_pkts, 0);
        chk("t5_no_drop", ct_drop_seen, 0);
        chk("t5_dcnt", ct_dcnt, 0);
        chk("t5_stalled", ct_stalls > 0, 1);
        chk("sf_queue_drained", sf_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
